ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX/MEM pipeline register for the five-stage core, replacing the fixed 32-bit register-writeback latch. It carries the GPR writeback, HI/LO writeback and load/store fields from EX to MEM, with a valid bit. It implements stall, bubble and flush control, and feeds the two-cycle multiply-accumulate intermediate state back to EX. A saturating bubble counter is exposed for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of GPR, HI, LO and memory data
- ADDR_W, 5, GPR address width
- MEMOP_W, 4, load/store opcode width (0 = no memory op)
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_stall  in  1  EX stage is stalled this cycle
- mem_stall  in  1  MEM stage is stalled this cycle
- flush  in  1  exception/eret flush; kill the in-flight instruction
- ex_valid  in  1  EX holds a real instruction
- ex_write_data  in  DATA_W  GPR writeback value
- ex_write_addr  in  ADDR_W  GPR writeback address
- ex_write_en  in  1  GPR write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO writeback values
- ex_whilo  in  1  HI/LO write enable
- ex_mem_op  in  MEMOP_W  load/store opcode
- ex_mem_addr  in  DATA_W  effective address
- ex_store_data  in  DATA_W  store data
- ex_hilo_temp  in  2*DATA_W  madd/msub partial product from EX
- ex_cnt  in  2  madd/msub cycle index from EX
- mem_valid  out  1
- mem_write_data, mem_write_addr, mem_write_en  out  DATA_W/ADDR_W/1
- mem_hi, mem_lo, mem_whilo  out  DATA_W/DATA_W/1
- mem_mem_op, mem_mem_addr, mem_store_data  out  MEMOP_W/DATA_W/DATA_W
- hilo_temp_fb  out  2*DATA_W  partial product returned to EX
- cnt_fb  out  2  cycle index returned to EX
- bubble_cnt  out  CNT_W  count of bubbles inserted, saturating

## Operation
Each rising edge selects exactly one action, in this priority order:
1. rst: all outputs are 0, including bubble_cnt, hilo_temp_fb and cnt_fb.
2. flush: payload registers and mem_valid are 0. hilo_temp_fb and cnt_fb are 0. bubble_cnt is unchanged.
3. mem_stall=1: every register holds, regardless of ex_stall.
4. ex_stall=1 and mem_stall=0 (bubble):
   - Payload registers and mem_valid are 0.
   - hilo_temp_fb is loaded with ex_hilo_temp and cnt_fb with ex_cnt, so a multi-cycle madd/msub in EX resumes with its partial state.
   - bubble_cnt increments by 1 and saturates at all-ones.
5. Otherwise (advance):
   - Every payload register loads its ex_* input.
   - mem_valid loads ex_valid.
   - hilo_temp_fb and cnt_fb are 0.

Further rules:
- Write enables are gated: mem_write_en, mem_whilo and a nonzero mem_mem_op are only ever captured when ex_valid=1. When ex_valid=0, these three are forced to 0 on advance.
- No arithmetic is performed on the payload; all fields are passed through at their declared widths.

## Timing
- Latency: 1 cycle from the EX inputs to the mem_* outputs.
- No combinational path from any input to any output; all outputs are registers.
- Reset and flush take effect on the edge they are sampled on, even mid-madd: cnt_fb returns to 0 and the partial product is discarded.
- A held value stays stable for any number of mem_stall cycles. When mem_stall deasserts, the held value is replaced on the next edge according to the priority order.
- Simultaneous flush and mem_stall: flush wins, and the held instruction is killed.
- bubble_cnt at all-ones stays at all-ones on further bubbles; it wraps only via rst.

## Test plan
- Reset: drive all inputs nonzero with rst=1 for 2 cycles → every output is 0. Deassert rst with ex_valid=1, ex_write_data=0xDEADBEEF, ex_write_addr=5, ex_write_en=1 → one cycle later mem_write_data=0xDEADBEEF, mem_write_addr=5, mem_write_en=1, mem_valid=1.
- Hold: load ex_hi=0x1234, ex_whilo=1, then mem_stall=1 for 3 cycles while the inputs change → mem_hi stays 0x1234 and mem_whilo stays 1 for all 3 cycles.
- Bubble and madd feedback: ex_stall=1, mem_stall=0, ex_hilo_temp=0x00000001_00000002, ex_cnt=1 → mem_valid=0, mem_write_en=0, hilo_temp_fb=0x00000001_00000002, cnt_fb=1, bubble_cnt increments 0→1. Next cycle advances → cnt_fb=0.
- Flush priority: flush=1 and mem_stall=1 with a valid store held (mem_mem_op=0x8) → next edge mem_mem_op=0, mem_valid=0, bubble_cnt unchanged.
- Invalid gating: ex_valid=0, ex_write_en=1, ex_whilo=1, ex_mem_op=0x3 on advance → mem_write_en=0, mem_whilo=0, mem_mem_op=0.
- Saturation: with CNT_W=4, apply 20 consecutive bubbles → bubble_cnt=0xF and stays there. Asserting rst returns it to 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: GPR, HI/LO and load/store payload plus valid, with
// stall/bubble/flush control, madd/msub state feedback to EX and a bubble counter.
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int MEMOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_stall,
  input  logic                mem_stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_write_data,
  input  logic [ADDR_W-1:0]   ex_write_addr,
  input  logic                ex_write_en,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [MEMOP_W-1:0]  ex_mem_op,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [1:0]          ex_cnt,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic [ADDR_W-1:0]   mem_write_addr,
  output logic                mem_write_en,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [MEMOP_W-1:0]  mem_mem_op,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_store_data,
  output logic [2*DATA_W-1:0] hilo_temp_fb,
  output logic [1:0]          cnt_fb,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Priority: rst > flush > mem_stall (hold) > ex_stall (bubble) > advance.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_valid      <= 1'b0;
      mem_write_data <= '0;
      mem_write_addr <= '0;
      mem_write_en   <= 1'b0;
      mem_hi         <= '0;
      mem_lo         <= '0;
      mem_whilo      <= 1'b0;
      mem_mem_op     <= '0;
      mem_mem_addr   <= '0;
      mem_store_data <= '0;
      hilo_temp_fb   <= '0;
      cnt_fb         <= '0;
      if (rst) bubble_cnt <= '0;
    end else if (mem_stall) begin
      // hold everything
    end else if (ex_stall) begin
      mem_valid      <= 1'b0;
      mem_write_data <= '0;
      mem_write_addr <= '0;
      mem_write_en   <= 1'b0;
      mem_hi         <= '0;
      mem_lo         <= '0;
      mem_whilo      <= 1'b0;
      mem_mem_op     <= '0;
      mem_mem_addr   <= '0;
      mem_store_data <= '0;
      // Stalled madd/msub keeps its partial state alive through the bubble.
      hilo_temp_fb   <= ex_hilo_temp;
      cnt_fb         <= ex_cnt;
      if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      mem_valid      <= ex_valid;
      mem_write_data <= ex_write_data;
      mem_write_addr <= ex_write_addr;
      mem_write_en   <= ex_valid & ex_write_en;
      mem_hi         <= ex_hi;
      mem_lo         <= ex_lo;
      mem_whilo      <= ex_valid & ex_whilo;
      mem_mem_op     <= ex_valid ? ex_mem_op : '0;
      mem_mem_addr   <= ex_mem_addr;
      mem_store_data <= ex_store_data;
      hilo_temp_fb   <= '0;
      cnt_fb         <= '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push hand-computed
// expected register state; a monitor pops and compares after each rising edge.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst, ex_stall, mem_stall, flush, ex_valid;
  logic [31:0] ex_write_data, ex_hi, ex_lo, ex_mem_addr, ex_store_data;
  logic [4:0]  ex_write_addr;
  logic        ex_write_en, ex_whilo;
  logic [3:0]  ex_mem_op;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic        mem_valid, mem_write_en, mem_whilo;
  logic [31:0] mem_write_data, mem_hi, mem_lo, mem_mem_addr, mem_store_data;
  logic [4:0]  mem_write_addr;
  logic [3:0]  mem_mem_op, bubble_cnt;
  logic [63:0] hilo_temp_fb;
  logic [1:0]  cnt_fb;

  typedef struct packed {
    logic v; logic [31:0] wd; logic [4:0] wa; logic we;
    logic [31:0] hi, lo; logic whilo; logic [3:0] op;
    logic [31:0] ma, sd; logic [63:0] fb; logic [1:0] cf; logic [3:0] bc;
  } exp_t;

  exp_t e;
  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .mem_stall(mem_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_write_data(ex_write_data), .ex_write_addr(ex_write_addr),
    .ex_write_en(ex_write_en), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt), .mem_valid(mem_valid),
    .mem_write_data(mem_write_data), .mem_write_addr(mem_write_addr),
    .mem_write_en(mem_write_en), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_mem_op(mem_mem_op), .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
    .hilo_temp_fb(hilo_temp_fb), .cnt_fb(cnt_fb), .bubble_cnt(bubble_cnt));

  task automatic chk(input string n, input int id, input logic [63:0] a, input logic [63:0] x);
    if (a !== x) begin
      nerr++;
      $display("FAIL vec%0d %s got %h want %h", id, n, a, x);
    end
  endtask

  // Monitor: every edge with a pending expectation is one applied vector.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("mem_valid", nvec, 64'(mem_valid), 64'(x.v));
      chk("mem_write_data", nvec, 64'(mem_write_data), 64'(x.wd));
      chk("mem_write_addr", nvec, 64'(mem_write_addr), 64'(x.wa));
      chk("mem_write_en", nvec, 64'(mem_write_en), 64'(x.we));
      chk("mem_hi", nvec, 64'(mem_hi), 64'(x.hi));
      chk("mem_lo", nvec, 64'(mem_lo), 64'(x.lo));
      chk("mem_whilo", nvec, 64'(mem_whilo), 64'(x.whilo));
      chk("mem_mem_op", nvec, 64'(mem_mem_op), 64'(x.op));
      chk("mem_mem_addr", nvec, 64'(mem_mem_addr), 64'(x.ma));
      chk("mem_store_data", nvec, 64'(mem_store_data), 64'(x.sd));
      chk("hilo_temp_fb", nvec, hilo_temp_fb, x.fb);
      chk("cnt_fb", nvec, 64'(cnt_fb), 64'(x.cf));
      chk("bubble_cnt", nvec, 64'(bubble_cnt), 64'(x.bc));
      nvec++;
    end
  end

  task automatic zero_in();
    rst = 0; ex_stall = 0; mem_stall = 0; flush = 0; ex_valid = 0;
    ex_write_data = '0; ex_write_addr = '0; ex_write_en = 0; ex_hi = '0; ex_lo = '0;
    ex_whilo = 0; ex_mem_op = '0; ex_mem_addr = '0; ex_store_data = '0;
    ex_hilo_temp = '0; ex_cnt = '0;
  endtask

  // Inputs are already set; queue the expected state after the coming edge.
  task automatic apply();
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got %0d vectors want completion", nvec);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bc_exp;
    zero_in();
    @(negedge clk);

    // Reset with every input nonzero
    rst = 1; ex_stall = 1; mem_stall = 1; flush = 1; ex_valid = 1;
    ex_write_data = 32'hFFFF_FFFF; ex_write_addr = 5'h1F; ex_write_en = 1;
    ex_hi = 32'hAAAA_AAAA; ex_lo = 32'h5555_5555; ex_whilo = 1; ex_mem_op = 4'hF;
    ex_mem_addr = 32'h1111_1111; ex_store_data = 32'h2222_2222;
    ex_hilo_temp = 64'h3333_3333_4444_4444; ex_cnt = 2'd3;
    e = '0;
    apply(); apply();

    // First instruction after reset
    zero_in(); ex_valid = 1; ex_write_data = 32'hDEADBEEF; ex_write_addr = 5; ex_write_en = 1;
    e = '0; e.v = 1; e.wd = 32'hDEADBEEF; e.wa = 5; e.we = 1;
    apply();

    // Load HI, then hold for 3 mem_stall cycles while inputs change
    zero_in(); ex_valid = 1; ex_hi = 32'h1234; ex_whilo = 1;
    e = '0; e.v = 1; e.hi = 32'h1234; e.whilo = 1;
    apply();
    for (int i = 0; i < 3; i++) begin
      zero_in(); mem_stall = 1; ex_stall = (i == 1); ex_valid = 1;
      ex_hi = 32'h9999_0000 + i; ex_whilo = 0; ex_write_data = 32'h77 + i; ex_write_en = 1;
      ex_hilo_temp = 64'hABCD; ex_cnt = 2;
      apply();
    end

    // Bubble carries madd partial state back to EX
    zero_in(); ex_stall = 1; ex_valid = 1; ex_write_en = 1; ex_write_data = 32'h42;
    ex_hilo_temp = 64'h00000001_00000002; ex_cnt = 1;
    e = '0; e.fb = 64'h00000001_00000002; e.cf = 1; e.bc = 1;
    apply();
    zero_in(); ex_valid = 1;
    e = '0; e.v = 1; e.bc = 1;
    apply();

    // Valid store, then a bubble mid-madd, then flush with mem_stall
    zero_in(); ex_valid = 1; ex_mem_op = 4'h8; ex_mem_addr = 32'h100; ex_store_data = 32'hCAFE;
    e = '0; e.v = 1; e.op = 4'h8; e.ma = 32'h100; e.sd = 32'hCAFE; e.bc = 1;
    apply();
    zero_in(); mem_stall = 1; ex_valid = 1; ex_mem_op = 4'h3;
    apply();
    zero_in(); flush = 1; mem_stall = 1; ex_stall = 1; ex_valid = 1; ex_mem_op = 4'h8;
    ex_hilo_temp = 64'hFFFF; ex_cnt = 2;
    e = '0; e.bc = 1;
    apply();
    zero_in(); ex_stall = 1; ex_hilo_temp = 64'h5_0000_0006; ex_cnt = 2;
    e = '0; e.fb = 64'h5_0000_0006; e.cf = 2; e.bc = 2;
    apply();
    zero_in(); flush = 1; ex_hilo_temp = 64'h9; ex_cnt = 3;
    e = '0; e.bc = 2;
    apply();

    // Invalid instruction: enables and mem op gated, data still passes
    zero_in(); ex_valid = 0; ex_write_en = 1; ex_whilo = 1; ex_mem_op = 4'h3;
    ex_write_data = 32'h55; ex_write_addr = 7; ex_hi = 32'h66; ex_lo = 32'h77;
    ex_mem_addr = 32'h88; ex_store_data = 32'h99;
    e = '0; e.wd = 32'h55; e.wa = 7; e.hi = 32'h66; e.lo = 32'h77; e.ma = 32'h88;
    e.sd = 32'h99; e.bc = 2;
    apply();

    // 20 bubbles: counter saturates at 0xF
    bc_exp = 2;
    for (int i = 0; i < 20; i++) begin
      zero_in(); ex_stall = 1; ex_valid = 1; ex_hilo_temp = 64'(i + 1); ex_cnt = 2'(i);
      if (bc_exp != 4'hF) bc_exp = bc_exp + 1;
      e = '0; e.fb = 64'(i + 1); e.cf = 2'(i); e.bc = bc_exp;
      apply();
    end

    // Reset clears the saturated counter
    zero_in(); rst = 1; ex_stall = 1;
    e = '0;
    apply();

    zero_in();
    @(negedge clk); @(negedge clk);
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
